// File: rtl/lcd_frame_streamer.sv
// Purpose: streams a 32-character LCD frame (line-1 message ROM, line-2 "Press Ok" plus BCD digits)
//          to an LCD controller, rebuilding the frame on input change, on refresh, or after reset.
// Latency: char_valid rises two edges after the triggering input edge (IDLE->LOAD->SEND); one char/cycle.
// Backpressure: char_valid/char_data/char_addr hold while char_ready=0; valid is never withdrawn.
// Ports: iCLK/iRST_N clock and async active-low reset; msg_sel/value/refresh from the feeder FSM;
//        char_data/char_addr/char_valid/char_ready handshake to the LCD controller; busy, frame_done status.
module lcd_frame_streamer #(
  parameter int MSG_W      = 3,
  parameter int NUM_DIGITS = 2,
  parameter int DIGIT_COL  = 12
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [MSG_W-1:0]        msg_sel,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    refresh,
  output logic [7:0]              char_data,
  output logic [4:0]              char_addr,
  output logic                    char_valid,
  input  logic                    char_ready,
  output logic                    busy,
  output logic                    frame_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [63:0] PROMPT = "Press Ok";

  logic [1:0]              state;
  logic [4:0]              idx;
  logic [MSG_W-1:0]        snap_msg;
  logic [4*NUM_DIGITS-1:0] snap_val;
  logic                    pending;
  logic                    changed;
  logic [7:0]              frame_char;

  // Line-1 text is stored right-justified; characters past the text length are spaces.
  function automatic logic [7:0] line1_char(input logic [MSG_W-1:0] m, input logic [3:0] col);
    logic [71:0] txt;
    int          len;
    int          c;
    logic [7:0]  ch;
    txt = '0;
    len = 0;
    c   = int'(col);
    ch  = 8'h20;
    case (int'(m))
      0:       begin txt = 72'("Start");     len = 5; end
      1:       begin txt = 72'("Set Clock"); len = 9; end
      2:       begin txt = 72'("Set Meal");  len = 8; end
      3:       begin txt = 72'("Set Time");  len = 8; end
      4:       begin txt = 72'("Set Size");  len = 8; end
      5:       begin txt = 72'("Done");      len = 4; end
      default: begin txt = '0;               len = 0; end
    endcase
    if (c < len) begin
      ch = txt[8*(len-1-c) +: 8];
    end
    return ch;
  endfunction

  function automatic logic [7:0] line2_char(input logic [4*NUM_DIGITS-1:0] v, input logic [3:0] col);
    int         c;
    logic [3:0] nib;
    logic [7:0] ch;
    c   = int'(col);
    ch  = 8'h20;
    nib = 4'h0;
    if (c < 8) begin
      ch = PROMPT[8*(7-c) +: 8];
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (c == DIGIT_COL + k) begin
        nib = v[4*(NUM_DIGITS-1-k) +: 4];
        // Non-BCD nibbles render as '-' so a corrupt value is visible on the panel.
        ch  = (nib > 4'd9) ? 8'h2D : {4'h3, nib};
      end
    end
    return ch;
  endfunction

  assign changed = ({msg_sel, value} != {snap_msg, snap_val});

  always_comb begin
    frame_char = 8'h00;
    if (!idx[4]) begin
      frame_char = line1_char(snap_msg, idx[3:0]);
    end else begin
      frame_char = line2_char(snap_val, idx[3:0]);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= ST_IDLE;
      idx      <= 5'd0;
      snap_msg <= '0;
      snap_val <= '0;
      pending  <= 1'b1;   // forces a frame out right after reset
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending || refresh || changed) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          snap_msg <= msg_sel;
          snap_val <= value;
          idx      <= 5'd0;
          // The snapshot absorbs any input change seen now; only a refresh here needs another frame.
          pending  <= refresh;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (refresh || changed) begin
            pending <= 1'b1;
          end
          if (char_ready) begin
            if (idx == 5'd31) begin
              state <= ST_DONE;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        default: begin  // ST_DONE
          if (refresh || changed) begin
            pending <= 1'b1;
          end
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode state and registers only; char_ready never reaches them combinationally.
  assign char_valid = (state == ST_SEND);
  assign char_addr  = char_valid ? idx : 5'd0;
  assign char_data  = char_valid ? frame_char : 8'h00;
  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_lcd_frame_streamer.sv
module tb_lcd_frame_streamer;
  localparam int MSG_W      = 3;
  localparam int NUM_DIGITS = 2;
  localparam int DIGIT_COL  = 12;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic [2:0] msg_sel;
  logic [7:0] value;
  logic       refresh;
  logic [7:0] char_data;
  logic [4:0] char_addr;
  logic       char_valid;
  logic       char_ready;
  logic       busy;
  logic       frame_done;

  logic bp_mode;
  logic bp_ready;
  logic ready_force;
  assign char_ready = bp_mode ? bp_ready : ready_force;

  always #5 iCLK = ~iCLK;

  lcd_frame_streamer #(.MSG_W(MSG_W), .NUM_DIGITS(NUM_DIGITS), .DIGIT_COL(DIGIT_COL)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .msg_sel(msg_sel), .value(value), .refresh(refresh),
    .char_data(char_data), .char_addr(char_addr), .char_valid(char_valid),
    .char_ready(char_ready), .busy(busy), .frame_done(frame_done)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference frame model built from ASCII strings.
  function automatic logic [7:0] model_char(input int msg, input logic [7:0] val, input int addr);
    string l1;
    string p;
    int    col;
    int    k;
    int    d;
    p = "Press Ok";
    case (msg)
      0:       l1 = "Start";
      1:       l1 = "Set Clock";
      2:       l1 = "Set Meal";
      3:       l1 = "Set Time";
      4:       l1 = "Set Size";
      5:       l1 = "Done";
      default: l1 = "";
    endcase
    col = addr % 16;
    if (addr < 16) return (col < l1.len()) ? l1[col] : 8'h20;
    if (col < 8) return p[col];
    if (col >= DIGIT_COL && col < DIGIT_COL + NUM_DIGITS) begin
      k = col - DIGIT_COL;
      d = (int'(val) >> (4*(NUM_DIGITS-1-k))) & 15;
      return (d > 9) ? 8'h2D : 8'(48 + d);
    end
    return 8'h20;
  endfunction

  logic [12:0] sb_q[$];

  task automatic push_frame(input int msg, input logic [7:0] val);
    for (int a = 0; a < 32; a++) begin
      sb_q.push_back({5'(a), model_char(msg, val, a)});
    end
  endtask

  // Monitor: everything sampled on the falling edge.
  int          xfer_count = 0;
  int          fd_count   = 0;
  int          send_cyc   = 0;
  logic        xfer_seen  = 1'b0;
  logic        hold_arm   = 1'b0;
  logic [4:0]  hold_addr  = '0;
  logic [7:0]  hold_data  = '0;
  logic [7:0]  cap[32];
  logic [12:0] exp_e;

  always @(negedge iCLK) begin
    if (!iRST_N) begin
      hold_arm  = 1'b0;
      xfer_seen = 1'b0;
    end else begin
      if (hold_arm) begin
        check("hold_valid", 32'(char_valid), 32'(1));
        check("hold_addr", 32'(char_addr), 32'(hold_addr));
        check("hold_data", 32'(char_data), 32'(hold_data));
      end
      hold_arm  = char_valid && !char_ready;
      hold_addr = char_addr;
      hold_data = char_data;
      xfer_seen = char_valid && char_ready;
      if (char_valid) send_cyc++;
      if (frame_done) begin
        fd_count++;
        check("done_busy", 32'(busy), 32'(1));
      end
      if (char_valid && char_ready) begin
        xfer_count++;
        cap[char_addr] = char_data;
        if (sb_q.size() == 0) begin
          check("unexpected_char", 32'(char_addr), 32'hFFFF);
        end else begin
          exp_e = sb_q.pop_front();
          check("char_addr", 32'(char_addr), 32'(exp_e[12:8]));
          check("char_data", 32'(char_data), 32'(exp_e[7:0]));
        end
      end
    end
  end

  // Back-pressure driver: ready is high in the first SEND cycle and low after every transfer.
  always @(posedge iCLK) begin
    #1;
    bp_ready = !xfer_seen;
  end

  task automatic tick();
    @(negedge iCLK);
    #1;
  endtask

  task automatic set_in(input logic [2:0] m, input logic [7:0] v);
    @(posedge iCLK);
    #1;
    msg_sel = m;
    value   = v;
  endtask

  task automatic pulse_refresh();
    @(posedge iCLK);
    #1;
    refresh = 1'b1;
    @(posedge iCLK);
    #1;
    refresh = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int target;
    int c;
    target = fd_count + n;
    c = 0;
    while (fd_count < target && c < 400) begin
      tick();
      c++;
    end
    if (fd_count < target) check("frame_timeout", 32'(fd_count), 32'(target));
  endtask

  task automatic wait_xfers(input int target);
    int c;
    c = 0;
    while (xfer_count < target && c < 400) begin
      tick();
      c++;
    end
    if (xfer_count < target) check("xfer_timeout", 32'(xfer_count), 32'(target));
  endtask

  task automatic idle_check(input int n, input string name);
    int v;
    v = 0;
    repeat (n) begin
      tick();
      if (char_valid || busy) v++;
    end
    check(name, 32'(v), 32'(0));
  endtask

  // Called at negedge+1 with reset low: release and check the LOAD cycle then first SEND cycle.
  task automatic release_and_check(input string tag);
    iRST_N = 1'b1;
    tick();
    check({tag, "_load_valid"}, 32'(char_valid), 32'(0));
    check({tag, "_load_busy"}, 32'(busy), 32'(1));
    tick();
    check({tag, "_first_valid"}, 32'(char_valid), 32'(1));
    check({tag, "_first_addr"}, 32'(char_addr), 32'(0));
  endtask

  typedef struct {
    logic [2:0] msg;
    logic [7:0] val;
    logic       bp;
    logic [4:0] a0; logic [7:0] d0;
    logic [4:0] a1; logic [7:0] d1;
    logic [4:0] a2; logic [7:0] d2;
    int         cyc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int fd0;
    int c0;
    int gap;
    int guard;

    vecs[0] = '{3'd1, 8'h42, 1'b1, 5'h00, 8'h53, 5'h08, 8'h6B, 5'h09, 8'h20, 63};
    vecs[1] = '{3'd7, 8'hA9, 1'b0, 5'h00, 8'h20, 5'h1C, 8'h2D, 5'h1D, 8'h39, 32};
    vecs[2] = '{3'd3, 8'h07, 1'b0, 5'h04, 8'h54, 5'h1C, 8'h30, 5'h1D, 8'h37, 32};
    vecs[3] = '{3'd4, 8'h9F, 1'b0, 5'h04, 8'h53, 5'h1C, 8'h39, 5'h1D, 8'h2D, 32};
    vecs[4] = '{3'd6, 8'h00, 1'b0, 5'h05, 8'h20, 5'h1C, 8'h30, 5'h1B, 8'h20, 32};

    iRST_N      = 1'b0;
    msg_sel     = 3'd0;
    value       = 8'h42;
    refresh     = 1'b0;
    bp_mode     = 1'b0;
    ready_force = 1'b1;

    // Reset state and the automatic frame after reset.
    tick();
    check("rst_valid", 32'(char_valid), 32'(0));
    check("rst_data", 32'(char_data), 32'(0));
    check("rst_addr", 32'(char_addr), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(frame_done), 32'(0));
    tick();
    push_frame(0, 8'h42);
    fd0 = fd_count;
    release_and_check("reset_frame");
    wait_frames(1);
    check("reset_frame_l1_0", 32'(cap[5'h00]), 32'h53);
    check("reset_frame_l1_4", 32'(cap[5'h04]), 32'h74);
    check("reset_frame_pad", 32'(cap[5'h05]), 32'h20);
    check("reset_frame_p", 32'(cap[5'h10]), 32'h50);
    check("reset_frame_k", 32'(cap[5'h17]), 32'h6B);
    check("reset_frame_d0", 32'(cap[5'h1C]), 32'h34);
    check("reset_frame_d1", 32'(cap[5'h1D]), 32'h32);
    idle_check(10, "reset_frame_idle");
    check("reset_frame_done_cnt", 32'(fd_count - fd0), 32'(1));

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      bp_mode = vecs[i].bp;
      set_in(vecs[i].msg, vecs[i].val);
      push_frame(int'(vecs[i].msg), vecs[i].val);
      c0 = send_cyc;
      wait_frames(1);
      check($sformatf("vec%0d_send_cycles", i), 32'(send_cyc - c0), 32'(vecs[i].cyc));
      check($sformatf("vec%0d_spot0", i), 32'(cap[vecs[i].a0]), 32'(vecs[i].d0));
      check($sformatf("vec%0d_spot1", i), 32'(cap[vecs[i].a1]), 32'(vecs[i].d1));
      check($sformatf("vec%0d_spot2", i), 32'(cap[vecs[i].a2]), 32'(vecs[i].d2));
      check($sformatf("vec%0d_sb_empty", i), 32'(sb_q.size()), 32'(0));
      tick();
      tick();
      bp_mode = 1'b0;
    end

    // Input change mid-frame: current frame finishes, exactly one follow-up frame.
    fd0 = fd_count;
    set_in(3'd2, 8'h12);
    push_frame(2, 8'h12);
    wait_xfers(xfer_count + 10);
    set_in(3'd5, 8'h12);
    push_frame(5, 8'h12);
    wait_frames(1);
    check("chg_l1_first", 32'(cap[5'h04]), 32'h4D);
    gap = 0;
    guard = 0;
    while (!char_valid && guard < 20) begin
      tick();
      if (!char_valid) gap++;
      guard++;
    end
    check("chg_gap", 32'(gap), 32'(2));
    check("chg_gap_addr", 32'(char_addr), 32'(0));
    wait_frames(1);
    check("chg_l1_second", 32'(cap[5'h00]), 32'h44);
    idle_check(40, "chg_no_third");
    check("chg_done_cnt", 32'(fd_count - fd0), 32'(2));
    check("chg_sb_empty", 32'(sb_q.size()), 32'(0));

    // Refresh in IDLE resends an identical frame.
    fd0 = fd_count;
    push_frame(5, 8'h12);
    pulse_refresh();
    wait_frames(1);
    idle_check(5, "refresh_idle");
    check("refresh_done_cnt", 32'(fd_count - fd0), 32'(1));
    check("refresh_sb_empty", 32'(sb_q.size()), 32'(0));

    // Two refresh pulses during SEND give exactly one extra frame.
    fd0 = fd_count;
    c0 = xfer_count;
    push_frame(5, 8'h12);
    pulse_refresh();
    wait_xfers(c0 + 5);
    pulse_refresh();
    wait_xfers(c0 + 15);
    pulse_refresh();
    push_frame(5, 8'h12);
    wait_frames(2);
    idle_check(40, "refresh2_no_third");
    check("refresh2_done_cnt", 32'(fd_count - fd0), 32'(2));
    check("refresh2_sb_empty", 32'(sb_q.size()), 32'(0));

    // Reset mid-frame aborts immediately; a fresh frame follows release.
    set_in(3'd0, 8'h55);
    push_frame(0, 8'h55);
    wait_xfers(xfer_count + 20);
    #2;
    iRST_N = 1'b0;
    #1;
    check("midrst_valid", 32'(char_valid), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_addr", 32'(char_addr), 32'(0));
    sb_q.delete();
    tick();
    tick();
    check("midrst_hold_valid", 32'(char_valid), 32'(0));
    push_frame(0, 8'h55);
    fd0 = fd_count;
    release_and_check("midrst");
    wait_frames(1);
    check("midrst_d0", 32'(cap[5'h1C]), 32'h35);
    idle_check(5, "midrst_idle");
    check("midrst_done_cnt", 32'(fd_count - fd0), 32'(1));
    check("final_sb_empty", 32'(sb_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
